// File: rtl/controle_genius_param_pkg.sv
// Shared definitions for the parametrised Genius (Simon) controller:
// state encodings, a constant clog2 helper and the round-limit rule.
package controle_genius_param_pkg;

  localparam int unsigned ESTADO_W = 5;

  // State codes are also exported on db_estado
  typedef enum logic [ESTADO_W-1:0] {
    ST_INICIAL       = 5'h00,
    ST_PREPARA       = 5'h01,
    ST_INICIA_RODADA = 5'h02,
    ST_MOSTRA        = 5'h03,
    ST_APAGA         = 5'h04,
    ST_PROX_MOSTRA   = 5'h05,
    ST_ESPERA        = 5'h06,
    ST_REGISTRA      = 5'h07,
    ST_COMPARA       = 5'h08,
    ST_PROXIMO       = 5'h09,
    ST_ULTIMA        = 5'h0A,
    ST_ESPERA_NOVA   = 5'h0B,
    ST_REGISTRA_NOVA = 5'h0C,
    ST_ESCREVE       = 5'h0D,
    ST_PROX_RODADA   = 5'h0E,
    ST_FIM_ACERTOU   = 5'h10,
    ST_FIM_ERROU     = 5'h11,
    ST_FIM_TIMEOUT   = 5'h12
  } estado_t;

  // Bits needed to hold values 0..v-1
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Last round index for the selected game length
  function automatic int unsigned limite_f(input logic longo, input int unsigned max_rodadas);
    return longo ? (max_rodadas - 1) : (max_rodadas / 2 - 1);
  endfunction

endpackage

// File: rtl/controle_genius_param_if.sv
// Sequence-RAM bus between the controller (master) and a RAM with
// combinational read (slave).
//   mem_dado     : read data at mem_endereco (RAM -> controller)
//   mem_endereco : address
//   mem_we       : one-cycle write strobe
//   mem_escrita  : write data (registered player move)
interface controle_genius_param_if #(
  parameter int unsigned N_BOTOES = 4,
  parameter int unsigned AW       = 4
);
  logic [N_BOTOES-1:0] mem_dado;
  logic [AW-1:0]       mem_endereco;
  logic                mem_we;
  logic [N_BOTOES-1:0] mem_escrita;

  modport master (input mem_dado, output mem_endereco, output mem_we, output mem_escrita);
  modport slave  (output mem_dado, input mem_endereco, input mem_we, input mem_escrita);
endinterface

// File: rtl/controle_genius_param_contador_m.sv
// Modulo-M counter used for the display, dark and timeout timers.
//   clock, reset : clock, async active-low reset
//   i_zera       : synchronous clear (has priority)
//   i_conta      : count enable, wraps M-1 -> 0
//   o_fim_c      : high while the count equals M-1
module controle_genius_param_contador_m
  import controle_genius_param_pkg::*;
#(
  parameter int unsigned M = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_zera,
  input  logic i_conta,
  output logic o_fim_c
);

  localparam int unsigned W = (clog2_f(M) == 0) ? 1 : clog2_f(M);

  logic [W-1:0] r_valor;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valor <= '0;
    end else if (i_zera) begin
      r_valor <= '0;
    end else if (i_conta) begin
      r_valor <= (r_valor == W'(M - 1)) ? '0 : r_valor + W'(1);
    end
  end

  assign o_fim_c = (r_valor == W'(M - 1));

endmodule

// File: rtl/controle_genius_param.sv
// Parametrised Genius (Simon) game controller with its own timers.
//   clock, reset           : clock, async active-low reset
//   iniciar                : start/restart request
//   modo_longo, modo_tempo : game length / timeout enable, latched in PREPARA
//   botoes                 : synchronised button levels
//   mem                    : sequence-RAM bus (master side)
//   leds                   : LED drive, RAM data shown during MOSTRA
//   rodada                 : current round, 0-based
//   pronto/acertou/errou/timeout : game result
//   db_estado              : current state code
module controle_genius_param
  import controle_genius_param_pkg::*;
#(
  parameter int unsigned N_BOTOES       = 4,
  parameter int unsigned MAX_RODADAS    = 16,
  parameter int unsigned AW             = 4,
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  parameter int unsigned EXIBE_CICLOS   = 1000,
  parameter int unsigned APAGA_CICLOS   = 250
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic                   modo_longo,
  input  logic                   modo_tempo,
  input  logic [N_BOTOES-1:0]    botoes,
  controle_genius_param_if.master mem,
  output logic [N_BOTOES-1:0]    leds,
  output logic [AW-1:0]          rodada,
  output logic                   pronto,
  output logic                   acertou,
  output logic                   errou,
  output logic                   timeout,
  output logic [ESTADO_W-1:0]    db_estado
);

  estado_t             r_estado;
  estado_t             w_prox;
  logic [AW-1:0]       r_endereco;
  logic [AW-1:0]       r_rodada;
  logic [N_BOTOES-1:0] r_botoes_q;
  logic [N_BOTOES-1:0] r_escrita;
  logic                r_modo_longo;
  logic                r_modo_tempo;

  logic w_jogada, w_erro, w_end_eq_rod, w_limite;
  logic w_fim_exibe, w_fim_apaga, w_fim_tempo, w_estouro;
  logic w_end_zera, w_end_inc, w_rod_zera, w_rod_inc;
  logic w_modos_carga, w_escrita_carga;
  logic w_zera_exibe, w_conta_exibe, w_zera_apaga, w_conta_apaga;
  logic w_zera_tempo, w_conta_tempo;

  // Rising edge of "any button pressed"
  assign w_jogada     = (|botoes) & ~(|r_botoes_q);
  // A chord (non-one-hot) is always a wrong move
  assign w_erro       = !$onehot(r_escrita) || (r_escrita != mem.mem_dado);
  assign w_end_eq_rod = (r_endereco == r_rodada);
  assign w_limite     = (r_rodada == AW'(limite_f(r_modo_longo, MAX_RODADAS)));
  // Timer stays frozen at zero when timeouts are disabled; gate anyway
  assign w_estouro    = w_fim_tempo & r_modo_tempo;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= ST_INICIAL;
    else        r_estado <= w_prox;
  end

  // Next-state logic
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      ST_INICIAL:       if (iniciar) w_prox = ST_PREPARA;
      ST_PREPARA:       w_prox = ST_INICIA_RODADA;
      ST_INICIA_RODADA: w_prox = ST_MOSTRA;
      ST_MOSTRA:        if (w_fim_exibe) w_prox = ST_APAGA;
      ST_APAGA:         if (w_fim_apaga) w_prox = w_end_eq_rod ? ST_ESPERA : ST_PROX_MOSTRA;
      ST_PROX_MOSTRA:   w_prox = ST_MOSTRA;
      ST_ESPERA: begin
        if (w_jogada)       w_prox = ST_REGISTRA;
        else if (w_estouro) w_prox = ST_FIM_TIMEOUT;
      end
      ST_REGISTRA:      w_prox = ST_COMPARA;
      ST_COMPARA: begin
        if (w_erro)            w_prox = ST_FIM_ERROU;
        else if (w_end_eq_rod) w_prox = ST_ULTIMA;
        else                   w_prox = ST_PROXIMO;
      end
      ST_PROXIMO:       w_prox = ST_ESPERA;
      ST_ULTIMA:        w_prox = w_limite ? ST_FIM_ACERTOU : ST_ESPERA_NOVA;
      ST_ESPERA_NOVA: begin
        if (w_jogada)       w_prox = ST_REGISTRA_NOVA;
        else if (w_estouro) w_prox = ST_FIM_TIMEOUT;
      end
      ST_REGISTRA_NOVA: w_prox = ST_ESCREVE;
      ST_ESCREVE:       w_prox = ST_PROX_RODADA;
      ST_PROX_RODADA:   w_prox = ST_INICIA_RODADA;
      ST_FIM_ACERTOU,
      ST_FIM_ERROU,
      ST_FIM_TIMEOUT:   if (iniciar) w_prox = ST_PREPARA;
      default:          w_prox = ST_INICIAL;
    endcase
  end

  // Moore outputs and datapath controls
  always_comb begin
    w_end_zera      = 1'b0;
    w_end_inc       = 1'b0;
    w_rod_zera      = 1'b0;
    w_rod_inc       = 1'b0;
    w_modos_carga   = 1'b0;
    w_escrita_carga = 1'b0;
    w_zera_exibe    = 1'b0;
    w_conta_exibe   = 1'b0;
    w_zera_apaga    = 1'b0;
    w_conta_apaga   = 1'b0;
    w_zera_tempo    = 1'b0;
    w_conta_tempo   = 1'b0;
    mem.mem_we      = 1'b0;
    leds            = '0;
    pronto          = 1'b0;
    acertou         = 1'b0;
    errou           = 1'b0;
    timeout         = 1'b0;
    case (r_estado)
      ST_PREPARA: begin
        w_end_zera    = 1'b1;
        w_rod_zera    = 1'b1;
        w_modos_carga = 1'b1;
        w_zera_exibe  = 1'b1;
        w_zera_apaga  = 1'b1;
        w_zera_tempo  = 1'b1;
      end
      ST_INICIA_RODADA: begin
        w_end_zera   = 1'b1;
        w_zera_exibe = 1'b1;
        w_zera_apaga = 1'b1;
      end
      ST_MOSTRA: begin
        leds          = mem.mem_dado;
        w_conta_exibe = 1'b1;
        w_zera_exibe  = w_fim_exibe;
        w_zera_apaga  = 1'b1;
      end
      ST_APAGA: begin
        w_conta_apaga = 1'b1;
        w_zera_tempo  = 1'b1;
        w_end_zera    = w_fim_apaga & w_end_eq_rod;
      end
      ST_PROX_MOSTRA: begin
        w_end_inc    = 1'b1;
        w_zera_exibe = 1'b1;
      end
      ST_ESPERA,
      ST_ESPERA_NOVA:   w_conta_tempo = r_modo_tempo;
      ST_REGISTRA,
      ST_REGISTRA_NOVA: w_escrita_carga = 1'b1;
      ST_PROXIMO: begin
        w_end_inc    = 1'b1;
        w_zera_tempo = 1'b1;
      end
      ST_ULTIMA: begin
        // Last round keeps the address so it never passes rodada+1
        w_end_inc    = ~w_limite;
        w_zera_tempo = 1'b1;
      end
      ST_ESCREVE:     mem.mem_we = 1'b1;
      ST_PROX_RODADA: w_rod_inc  = 1'b1;
      ST_FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      ST_FIM_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      ST_FIM_TIMEOUT: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  // Address and round counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_endereco <= '0;
      r_rodada   <= '0;
    end else begin
      if (w_end_zera)     r_endereco <= '0;
      else if (w_end_inc) r_endereco <= r_endereco + AW'(1);
      if (w_rod_zera)     r_rodada <= '0;
      else if (w_rod_inc) r_rodada <= r_rodada + AW'(1);
    end
  end

  // Button edge history, latched move and mode bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_botoes_q   <= '0;
      r_escrita    <= '0;
      r_modo_longo <= 1'b0;
      r_modo_tempo <= 1'b0;
    end else begin
      r_botoes_q <= botoes;
      if (w_escrita_carga) r_escrita <= botoes;
      if (w_modos_carga) begin
        r_modo_longo <= modo_longo;
        r_modo_tempo <= modo_tempo;
      end
    end
  end

  controle_genius_param_contador_m #(.M(EXIBE_CICLOS)) u_exibe (
    .clock   (clock),
    .reset   (reset),
    .i_zera  (w_zera_exibe),
    .i_conta (w_conta_exibe),
    .o_fim_c (w_fim_exibe)
  );

  controle_genius_param_contador_m #(.M(APAGA_CICLOS)) u_apaga (
    .clock   (clock),
    .reset   (reset),
    .i_zera  (w_zera_apaga),
    .i_conta (w_conta_apaga),
    .o_fim_c (w_fim_apaga)
  );

  controle_genius_param_contador_m #(.M(TIMEOUT_CICLOS)) u_tempo (
    .clock   (clock),
    .reset   (reset),
    .i_zera  (w_zera_tempo),
    .i_conta (w_conta_tempo),
    .o_fim_c (w_fim_tempo)
  );

  assign mem.mem_endereco = r_endereco;
  assign mem.mem_escrita  = r_escrita;
  assign rodada           = r_rodada;
  assign db_estado        = r_estado;

endmodule

// File: tb/tb_controle_genius_param.sv
// Directed/randomised bench for controle_genius_param with a game-level
// reference model (expected sequence, move legality, cycle timing).
module tb_controle_genius_param;

  localparam int unsigned N     = 4;
  localparam int unsigned MAX_R = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned T     = 20;
  localparam int unsigned EXIBE = 5;
  localparam int unsigned APAGA = 3;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          iniciar, modo_longo, modo_tempo;
  logic [N-1:0]  botoes;
  logic [N-1:0]  leds;
  logic [AW-1:0] rodada;
  logic          pronto, acertou, errou, timeout;
  logic [4:0]    db_estado;

  logic [N-1:0]  ram [0:MAX_R-1];
  logic [N-1:0]  exp_seq [0:MAX_R-1];
  int            n_we = 0;
  int            exp_we = 0;
  int            n_checks = 0;
  int            n_err = 0;

  controle_genius_param_if #(.N_BOTOES(N), .AW(AW)) bus ();

  controle_genius_param #(
    .N_BOTOES(N), .MAX_RODADAS(MAX_R), .AW(AW),
    .TIMEOUT_CICLOS(T), .EXIBE_CICLOS(EXIBE), .APAGA_CICLOS(APAGA)
  ) dut (
    .clock      (clock),
    .reset      (rst_n),
    .iniciar    (iniciar),
    .modo_longo (modo_longo),
    .modo_tempo (modo_tempo),
    .botoes     (botoes),
    .mem        (bus),
    .leds       (leds),
    .rodada     (rodada),
    .pronto     (pronto),
    .acertou    (acertou),
    .errou      (errou),
    .timeout    (timeout),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  // Sequence RAM: combinational read, write sampled mid-cycle, element 0 preloaded in reset
  assign bus.mem_dado = ram[bus.mem_endereco];
  always @(negedge clock) begin
    if (!rst_n) ram[0] <= 4'b0001;
    else if (bus.mem_we) begin
      ram[bus.mem_endereco] <= bus.mem_escrita;
      n_we <= n_we + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic bit move_ok(input logic [N-1:0] v, input logic [N-1:0] e);
    int ones;
    ones = 0;
    for (int b = 0; b < N; b++) if (v[b]) ones++;
    return (ones == 1) && (v == e);
  endfunction

  // From INICIAL or a FIM state to the first MOSTRA cycle
  task automatic start_game(input bit longo, input bit tempo);
    modo_longo = longo;
    modo_tempo = tempo;
    iniciar    = 1'b1;
    tick();
    chk("prepara", 32'(db_estado), 32'h01);
    chk("prepara_pronto", 32'(pronto), 0);
    iniciar = 1'b0;
    tick();
    chk("inicia_rodada", 32'(db_estado), 32'h02);
    chk("rodada_zero", 32'(rodada), 0);
    // Modes must already be latched; flipping inputs must not matter
    modo_longo = ~longo;
    modo_tempo = ~tempo;
    tick();
  endtask

  // Checks the playback of round r; ends observing the first ESPERA cycle
  task automatic playback(input int r);
    int n_on, n_off;
    for (int k = 0; k <= r; k++) begin
      n_on = 0;
      for (int c = 0; c < int'(EXIBE); c++) begin
        if (db_estado == 5'h03 && leds == exp_seq[k]) n_on++;
        tick();
      end
      chk("mostra_ciclos", 32'(n_on), EXIBE);
      n_off = 0;
      for (int c = 0; c < int'(APAGA); c++) begin
        if (db_estado == 5'h04 && leds == '0) n_off++;
        tick();
      end
      chk("apaga_ciclos", 32'(n_off), APAGA);
      if (k < r) begin
        chk("prox_mostra", 32'(db_estado), 32'h05);
        tick();
      end
    end
    chk("espera", 32'(db_estado), 32'h06);
  endtask

  task automatic play_game(input bit longo, input bit tempo, input int fail_r, input int fail_i,
                           input logic [N-1:0] bad, input logic [N-1:0] first_new);
    int lim;
    logic [N-1:0] v;
    bit ok;
    lim = longo ? int'(MAX_R) - 1 : int'(MAX_R) / 2 - 1;
    start_game(longo, tempo);
    for (int r = 0; r <= lim; r++) begin
      playback(r);
      chk("rodada", 32'(rodada), r);
      for (int i = 0; i <= r; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        v  = (r == fail_r && i == fail_i) ? bad : exp_seq[i];
        ok = move_ok(v, exp_seq[i]);
        botoes = v;
        tick();
        chk("registra", 32'(db_estado), 32'h07);
        tick();
        chk("compara", 32'(db_estado), 32'h08);
        chk("escrita_latch", 32'(bus.mem_escrita), 32'(v));
        botoes = '0;
        tick();
        if (!ok) begin
          chk("fim_errou", 32'(db_estado), 32'h11);
          chk("errou", 32'(errou), 1);
          chk("pronto_err", 32'(pronto), 1);
          chk("acertou_err", 32'(acertou), 0);
          chk("we_count_err", 32'(n_we), 32'(exp_we));
          return;
        end
        if (i < r) begin
          chk("proximo", 32'(db_estado), 32'h09);
          tick();
          chk("espera_prox", 32'(db_estado), 32'h06);
        end
      end
      chk("ultima", 32'(db_estado), 32'h0A);
      tick();
      if (r == lim) begin
        chk("fim_acertou", 32'(db_estado), 32'h10);
        chk("acertou", 32'(acertou), 1);
        chk("pronto_win", 32'(pronto), 1);
        chk("rodada_win", 32'(rodada), r);
        chk("we_count_win", 32'(n_we), 32'(exp_we));
        for (int k = 0; k <= lim; k++) chk("ram_seq", 32'(ram[k]), 32'(exp_seq[k]));
        return;
      end
      chk("espera_nova", 32'(db_estado), 32'h0B);
      v = (r == 0 && first_new != '0) ? first_new : N'(1 << $urandom_range(0, N - 1));
      repeat ($urandom_range(0, 3)) tick();
      botoes = v;
      tick();
      chk("registra_nova", 32'(db_estado), 32'h0C);
      tick();
      chk("escreve", 32'(db_estado), 32'h0D);
      chk("mem_we", 32'(bus.mem_we), 1);
      chk("mem_end_escreve", 32'(bus.mem_endereco), 32'(r + 1));
      botoes = '0;
      tick();
      chk("prox_rodada", 32'(db_estado), 32'h0E);
      exp_seq[r + 1] = v;
      exp_we++;
      tick();
      chk("nova_rodada", 32'(db_estado), 32'h02);
      tick();
    end
  endtask

  task automatic abort_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_estado", 32'(db_estado), 0);
    chk("rst_leds", 32'(leds), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("pos_rst_inicial", 32'(db_estado), 0);
  endtask

  initial begin
    int fr, fi;
    bit lg;
    rst_n      = 1'b0;
    iniciar    = 1'b0;
    modo_longo = 1'b0;
    modo_tempo = 1'b0;
    botoes     = '0;
    exp_seq[0] = 4'b0001;
    repeat (3) tick();
    chk("reset_estado", 32'(db_estado), 0);
    chk("reset_leds", 32'(leds), 0);
    chk("reset_we", 32'(bus.mem_we), 0);
    chk("reset_flags", 32'({pronto, acertou, errou, timeout}), 0);
    chk("reset_rodada", 32'(rodada), 0);
    chk("reset_end", 32'(bus.mem_endereco), 0);
    chk("reset_escrita", 32'(bus.mem_escrita), 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_inicial", 32'(db_estado), 0);

    // Short game win, then a wrong press in round 1, then a chord in round 0
    play_game(1'b0, 1'b1, -1, 0, '0, 4'b0010);
    play_game(1'b0, 1'b1, 1, 1, 4'b1000, 4'b0010);
    play_game(1'b0, 1'b0, 0, 0, 4'b0011, '0);
    // Long game win
    play_game(1'b1, 1'b1, -1, 0, '0, '0);

    // Timeout after exactly T cycles in ESPERA
    start_game(1'b0, 1'b1);
    playback(0);
    repeat (T - 1) tick();
    chk("espera_antes_to", 32'(db_estado), 32'h06);
    tick();
    chk("fim_timeout", 32'(db_estado), 32'h12);
    chk("timeout_flag", 32'({pronto, timeout, errou, acertou}), 32'b1100);

    // Timeout disabled: waits indefinitely, then a wrong press ends it
    start_game(1'b0, 1'b0);
    playback(0);
    repeat (3 * T) tick();
    chk("sem_timeout", 32'(db_estado), 32'h06);
    chk("sem_timeout_flag", 32'(timeout), 0);
    botoes = 4'b0100;
    tick();
    chk("registra_tarde", 32'(db_estado), 32'h07);
    tick();
    botoes = '0;
    tick();
    chk("errou_tarde", 32'(db_estado), 32'h11);

    // Press arriving on the timeout cycle wins over the timeout
    start_game(1'b0, 1'b1);
    playback(0);
    repeat (T - 1) tick();
    chk("espera_ultimo_ciclo", 32'(db_estado), 32'h06);
    botoes = exp_seq[0];
    tick();
    chk("jogada_prioridade", 32'(db_estado), 32'h07);
    tick();
    botoes = '0;
    tick();
    chk("ultima_pos_prio", 32'(db_estado), 32'h0A);
    tick();
    chk("espera_nova_pos_prio", 32'(db_estado), 32'h0B);
    abort_reset();

    // Random games
    for (int g = 0; g < 4; g++) begin
      lg = 1'($urandom_range(0, 1));
      fr = int'($urandom_range(0, 4)) - 1;
      fi = int'($urandom_range(0, 3));
      play_game(lg, 1'($urandom_range(0, 1)), fr, fi, N'($urandom_range(1, 15)), '0);
    end

    // Reset in the middle of MOSTRA
    start_game(1'b0, 1'b0);
    tick();
    tick();
    chk("mostra_pre_reset", 32'(leds), 32'(exp_seq[0]));
    abort_reset();
    chk("we_pos_reset", 32'(n_we), 32'(exp_we));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
